instr_fetch_unit: RTL

Read-side initiator for the 256-word instruction RAM: holds the program counter, drives the RAM's address and read-enable, captures returned words into a small prefetch buffer, and hands instructions to the decode stage over a valid/ready handshake. Sits between `instr_ram` (combinational read, registered write) and the decoder. It also accepts branch redirects from execute, and it stops fetching on halt or on an out-of-range PC.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 36 +++
 rtl/instr_fetch_unit.sv | 63 ++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, memory bounds and prefetch entry type for the fetch unit
package fetch_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MEM_WORDS = 256;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO; flush wins over push and pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   pushData,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Empty buffer presents zeros so Instr/InstrPC read 0 out of reset
  assign head = (count == '0) ? '0 : mem[rdPtr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing, RAM read requests and prefetch handoff to decode
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] MemAddress,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemDataIn,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  input  logic              Halt,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              Fault
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] pc;
  logic fault, fetch, pop, push, inRange;
  logic [CW-1:0] count;
  fetch_entry_t head, pushData;
  assign InstrValid = count != '0;
  // A handshake coinciding with a redirect is squashed, so it must not pop
  always_comb begin
    pop = InstrValid && InstrReady && !Redirect;
    fetch = reset_n && !Halt && !fault && !Redirect &&
            (count < CW'(DEPTH) || (InstrValid && InstrReady));
    inRange = pc < ADDR_W'(MEM_WORDS);
    push = fetch && inRange;
    pushData = '{pc: pc, instr: MemDataIn};
  end
  assign MemRead = push;
  assign MemAddress = pc;
  assign Instr = head.instr;
  assign InstrPC = head.pc;
  assign Fault = fault;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
      fault <= 1'b0;
    end else if (Redirect) begin
      pc <= RedirectPC;
      fault <= 1'b0;
    end else begin
      pc <= push ? pc + ADDR_W'(1) : pc;
      fault <= fault || (fetch && !inRange);
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .flush    (Redirect),
    .pushData (pushData),
    .head     (head),
    .count    (count)
  );
endmodule
